// File: rtl/instr_pkg.sv
// Shared instruction types for the front end: the raw word, its field positions,
// the base RV64I major opcodes and the packed set of decoded register/function fields.
package instr_pkg;

  typedef logic [31:0] instr_t;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_IMM_32 = 7'h1B,
    OP_STORE  = 7'h23,
    OP        = 7'h33,
    OP_LUI    = 7'h37,
    OP_32     = 7'h3B,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 32-bit RISC-V word into its fixed-position fields.
// Kept separate so the later decoder stage can reuse it unchanged.
module instr_field_decode
  import instr_pkg::*;
(
  input  instr_t        instr,
  output instr_fields_t fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPC_MSB:OPC_LSB];
    fields.rd     = instr[RD_MSB:RD_LSB];
    fields.funct3 = instr[F3_MSB:F3_LSB];
    fields.rs1    = instr[RS1_MSB:RS1_LSB];
    fields.rs2    = instr[RS2_MSB:RS2_LSB];
    fields.funct7 = instr[F7_MSB:F7_LSB];
  end

endmodule

// File: rtl/instr_queue_64.sv
// Instruction FIFO between fetch and decode/control: valid/ready on both sides,
// synchronous flush for redirects, head entry exposed with its decoded fields.
module instr_queue_64
  import instr_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_funct3,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [6:0]                 out_funct7,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  instr_fields_t      head_fields;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A full queue refuses pushes even when the head leaves in the same cycle.
  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  assign in_ready  = !full;
  assign out_valid = !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Flush leaves storage alone; stale entries stay hidden behind out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end
  end

  instr_field_decode u_decode (
    .instr  (instr_t'(out_instr)),
    .fields (head_fields)
  );

  assign out_opcode = head_fields.opcode;
  assign out_rd     = head_fields.rd;
  assign out_funct3 = head_fields.funct3;
  assign out_rs1    = head_fields.rs1;
  assign out_rs2    = head_fields.rs2;
  assign out_funct7 = head_fields.funct7;

  // Handshake flags must always agree with the occupancy count.
  a_full_iff_not_ready : assert property (
    @(posedge clk) disable iff (!reset) (count == CNT_W'(DEPTH)) == !in_ready);

  a_empty_iff_not_valid : assert property (
    @(posedge clk) disable iff (!reset) (count == '0) == !out_valid);

  a_head_hold : assert property (
    @(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !flush) |=> ($stable(out_instr) && $stable(out_pc)));

endmodule

// File: tb/tb_instr_queue_64.sv
// Self-checking bench for instr_queue_64: directed scenarios on DEPTH=4 plus a
// shared-stimulus sweep and random run across DEPTH=2/4/8 against queue models.
module tb_instr_queue_64;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        ir2, ov2, ir4, ov4, ir8, ov8;
  logic [31:0] oi2, oi4, oi8;
  logic [63:0] op2, op4, op8;
  logic [6:0]  opc2, opc4, opc8, f7_2, f7_4, f7_8;
  logic [4:0]  rd2, rd4, rd8, rs1_2, rs1_4, rs1_8, rs2_2, rs2_4, rs2_8;
  logic [2:0]  f3_2, f3_4, f3_8;
  logic [1:0]  cnt2;
  logic [2:0]  cnt4;
  logic [3:0]  cnt8;

  int n_cmp;
  int n_fail;

  instr_queue_64 #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov2), .out_ready(out_ready),
    .out_instr(oi2), .out_pc(op2), .out_opcode(opc2), .out_rd(rd2), .out_funct3(f3_2),
    .out_rs1(rs1_2), .out_rs2(rs2_2), .out_funct7(f7_2), .count(cnt2));

  instr_queue_64 #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov4), .out_ready(out_ready),
    .out_instr(oi4), .out_pc(op4), .out_opcode(opc4), .out_rd(rd4), .out_funct3(f3_4),
    .out_rs1(rs1_4), .out_rs2(rs2_4), .out_funct7(f7_4), .count(cnt4));

  instr_queue_64 #(.DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov8), .out_ready(out_ready),
    .out_instr(oi8), .out_pc(op8), .out_opcode(opc8), .out_rd(rd8), .out_funct3(f3_8),
    .out_rs1(rs1_8), .out_rs2(rs2_8), .out_funct7(f7_8), .count(cnt8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush_all();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_instr = base + 32'(i); in_pc = 64'h2000 + 64'(4 * i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #1;
    n_cmp++;
    if ({cnt4, ov4, ir4, oi4, op4, opc4} !== {3'd0, 1'b0, 1'b1, 32'h0, 64'h0, 7'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state got cnt=%0d v=%b r=%b instr=%h pc=%h exp cnt=0 v=0 r=1 instr=0 pc=0",
               cnt4, ov4, ir4, oi4, op4);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_field_decode();
    in_valid = 1'b1; in_instr = 32'h00A30293; in_pc = 64'h100; out_ready = 1'b0;
    n_cmp++;
    if (ov4 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL no_bypass got v=%b exp v=0", ov4);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({ov4, opc4, rd4, f3_4, rs1_4, rs2_4, f7_4, op4} !==
        {1'b1, 7'h13, 5'd5, 3'd0, 5'd6, 5'd10, 7'h0, 64'h100}) begin
      n_fail++;
      $display("[TB] FAIL field_decode got v=%b opc=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h pc=%h exp v=1 opc=13 rd=5 f3=0 rs1=6 rs2=10 f7=0 pc=100",
               ov4, opc4, rd4, f3_4, rs1_4, rs2_4, f7_4, op4);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if ({ov4, oi4, opc4, op4} !== {1'b0, 32'h0, 7'h0, 64'h0}) begin
      n_fail++;
      $display("[TB] FAIL pop_to_empty got v=%b instr=%h opc=%h pc=%h exp v=0 instr=0 opc=0 pc=0",
               ov4, oi4, opc4, op4);
    end
    flush_all();
  endtask

  task automatic test_fill_full();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = w[i]; in_pc = 64'h1000 + 64'(4 * i);
      step();
    end
    n_cmp++;
    if ({cnt4, ir4, oi4} !== {3'd4, 1'b0, w[0]}) begin
      n_fail++;
      $display("[TB] FAIL fill_full got cnt=%0d r=%b head=%h exp cnt=4 r=0 head=%h", cnt4, ir4, oi4, w[0]);
    end
    in_instr = w[4]; in_pc = 64'h1010;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if ({cnt4, oi4} !== {3'd4, w[0]}) begin
      n_fail++;
      $display("[TB] FAIL push_when_full got cnt=%0d head=%h exp cnt=4 head=%h", cnt4, oi4, w[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ov4, oi4, op4} !== {1'b1, w[i], 64'h1000 + 64'(4 * i)}) begin
        n_fail++;
        $display("[TB] FAIL drain_order[%0d] got v=%b instr=%h pc=%h exp v=1 instr=%h pc=%h",
                 i, ov4, oi4, op4, w[i], 64'h1000 + 64'(4 * i));
      end
      step();
    end
    n_cmp++;
    if ({ov4, cnt4} !== {1'b0, 3'd0}) begin
      n_fail++; $display("[TB] FAIL drained_empty got v=%b cnt=%0d exp v=0 cnt=0", ov4, cnt4);
    end
    flush_all();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom; exp_q.push_back(w);
      in_valid = 1'b1; in_instr = w; in_pc = 64'h3000;
      step();
    end
    for (int c = 0; c < 8; c++) begin
      w = $urandom;
      in_valid = 1'b1; in_instr = w; out_ready = 1'b1;
      n_cmp++;
      if ({cnt4, oi4} !== {3'd2, exp_q[0]}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back[%0d] got cnt=%0d head=%h exp cnt=2 head=%h", c, cnt4, oi4, exp_q[0]);
      end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(w);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({cnt4, oi4} !== {3'd2, exp_q[0]}) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_end got cnt=%0d head=%h exp cnt=2 head=%h", cnt4, oi4, exp_q[0]);
    end
    flush_all();
  endtask

  task automatic test_flush();
    push_words(3, 32'h5500_0000);
    n_cmp++;
    if (cnt4 !== 3'd3) begin
      n_fail++; $display("[TB] FAIL flush_prefill got cnt=%0d exp cnt=3", cnt4);
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({cnt4, ov4, ir4} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL flush got cnt=%0d v=%b r=%b exp cnt=0 v=0 r=1", cnt4, ov4, ir4);
    end
    step();
    out_ready = 1'b0;
    n_cmp++;
    if ({ov4, oi4} !== {1'b0, 32'h0}) begin
      n_fail++; $display("[TB] FAIL flush_push_dropped got v=%b instr=%h exp v=0 instr=0", ov4, oi4);
    end
  endtask

  task automatic test_async_reset();
    push_words(3, 32'h7700_0000);
    n_cmp++;
    if (cnt4 !== 3'd3) begin
      n_fail++; $display("[TB] FAIL areset_prefill got cnt=%0d exp cnt=3", cnt4);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({cnt4, ov4, ir4, oi4} !== {3'd0, 1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL async_reset got cnt=%0d v=%b r=%b instr=%h exp cnt=0 v=0 r=1 instr=0",
               cnt4, ov4, ir4, oi4);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_param_sweep();
    logic [31:0] w [8];
    for (int i = 0; i < 8; i++) w[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
    flush_all();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_instr = w[k]; in_pc = 64'h4000 + 64'(4 * k);
      step();
      n_cmp++;
      if ({cnt2, ir2, cnt8, ir8} !== {2'((k + 1 < 2) ? k + 1 : 2), 1'(k + 1 < 2), 4'(k + 1), 1'(k + 1 < 8)}) begin
        n_fail++;
        $display("[TB] FAIL sweep_fill[%0d] got d2 cnt=%0d r=%b d8 cnt=%0d r=%b exp d2 cnt=%0d r=%b d8 cnt=%0d r=%b",
                 k, cnt2, ir2, cnt8, ir8, (k + 1 < 2) ? k + 1 : 2, k + 1 < 2, k + 1, k + 1 < 8);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({ov8, oi8} !== {1'b1, w[i]} || ov2 !== 1'(i < 2) || (i < 2 && oi2 !== w[i])) begin
        n_fail++;
        $display("[TB] FAIL sweep_drain[%0d] got d8 v=%b instr=%h d2 v=%b instr=%h exp d8 v=1 instr=%h d2 v=%b",
                 i, ov8, oi8, ov2, oi2, w[i], i < 2);
      end
      step();
    end
    flush_all();
  endtask

  task automatic test_random();
    logic [95:0] q2[$], q4[$], q8[$];
    logic [95:0] h2, h4, h8;
    logic        pu2, pu4, pu8, po2, po4, po8;
    flush_all();
    for (int c = 0; c < 400; c++) begin
      h2 = (q2.size() > 0) ? q2[0] : 96'h0;
      h4 = (q4.size() > 0) ? q4[0] : 96'h0;
      h8 = (q8.size() > 0) ? q8[0] : 96'h0;
      n_cmp++;
      if ({ov2, ir2, cnt2, oi2, op2} !== {1'(q2.size() > 0), 1'(q2.size() < 2), 2'(q2.size()), h2[31:0], h2[95:32]}) begin
        n_fail++;
        $display("[TB] FAIL rand_d2 cyc=%0d got v=%b r=%b cnt=%0d instr=%h pc=%h exp cnt=%0d instr=%h pc=%h",
                 c, ov2, ir2, cnt2, oi2, op2, q2.size(), h2[31:0], h2[95:32]);
      end
      n_cmp++;
      if ({ov4, ir4, cnt4, oi4, op4, opc4, rs2_4} !== {1'(q4.size() > 0), 1'(q4.size() < 4), 3'(q4.size()),
                                                      h4[31:0], h4[95:32], h4[6:0], h4[24:20]}) begin
        n_fail++;
        $display("[TB] FAIL rand_d4 cyc=%0d got v=%b r=%b cnt=%0d instr=%h pc=%h exp cnt=%0d instr=%h pc=%h",
                 c, ov4, ir4, cnt4, oi4, op4, q4.size(), h4[31:0], h4[95:32]);
      end
      n_cmp++;
      if ({ov8, ir8, cnt8, oi8, op8} !== {1'(q8.size() > 0), 1'(q8.size() < 8), 4'(q8.size()), h8[31:0], h8[95:32]}) begin
        n_fail++;
        $display("[TB] FAIL rand_d8 cyc=%0d got v=%b r=%b cnt=%0d instr=%h pc=%h exp cnt=%0d instr=%h pc=%h",
                 c, ov8, ir8, cnt8, oi8, op8, q8.size(), h8[31:0], h8[95:32]);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = $urandom;
      in_pc     = {$urandom, $urandom};
      pu2 = in_valid && q2.size() < 2;  po2 = out_ready && q2.size() > 0;
      pu4 = in_valid && q4.size() < 4;  po4 = out_ready && q4.size() > 0;
      pu8 = in_valid && q8.size() < 8;  po8 = out_ready && q8.size() > 0;
      if (flush) begin
        q2.delete(); q4.delete(); q8.delete();
      end else begin
        if (po2) void'(q2.pop_front());
        if (po4) void'(q4.pop_front());
        if (po8) void'(q8.pop_front());
        if (pu2) q2.push_back({in_pc, in_instr});
        if (pu4) q4.push_back({in_pc, in_instr});
        if (pu8) q8.push_back({in_pc, in_instr});
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_field_decode();
    test_fill_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_param_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
